// File: rtl/digit_counter_mod_pkg.sv
// Shared 7-segment definitions for the clock display digits.
// Patterns are {g,f,e,d,c,b,a} and active-low; active-high users invert them.
package digit_counter_mod_pkg;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = SEG_A;
            4'hB:    pattern = SEG_B;
            4'hC:    pattern = SEG_C;
            4'hD:    pattern = SEG_D;
            4'hE:    pattern = SEG_E;
            default: pattern = SEG_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/digit_counter_mod_seg7_decode.sv
// Combinational hex-to-7-segment decoder shared by every display digit.
// Values that do not fit in one hex digit are shown blank.
module seg7_decode
    import digit_counter_mod_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SEG_ACT_LO = 1
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_blank,
    output logic [6:0]       o_seg
);

    logic       w_over;
    logic [3:0] w_nib;
    logic [6:0] w_seg_lo;

    generate
        if (WIDTH > 4) begin : g_wide
            assign w_over = |i_val[WIDTH-1:4];
        end else begin : g_narrow
            assign w_over = 1'b0;
        end
    endgenerate

    assign w_nib    = 4'(i_val);
    assign w_seg_lo = (i_blank || w_over) ? SEG_OFF : seg_lookup(w_nib);

    generate
        if (SEG_ACT_LO != 0) begin : g_act_lo
            assign o_seg = w_seg_lo;
        end else begin : g_act_hi
            assign o_seg = ~w_seg_lo;
        end
    endgenerate

endmodule

// File: rtl/digit_counter_mod.sv
// Single clock-display digit: up/down modulo counter with run-time limit,
// parallel load, registered 7-segment output and carry/borrow enable pulses.
module digit_counter_mod
    import digit_counter_mod_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MODULO     = 10,
    parameter int RESET_VAL  = 0,
    parameter int SEG_ACT_LO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] lim,
    input  logic             blank,
    output logic [WIDTH-1:0] value,
    output logic [6:0]       seg,
    output logic             carry,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] TOP_STATIC = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST_VALUE  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO       = '0;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0] r_value;
    logic [6:0]       r_seg;
    logic             r_carry;
    logic             r_borrow;

    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_value_next;
    logic             w_carry_next;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_dec_in;
    logic             w_dec_blank;
    logic [6:0]       w_seg_next;

    assign w_top = (lim > TOP_STATIC) ? TOP_STATIC : lim;

    // A value left above a lowered limit is only corrected on the next en/ld.
    always_comb begin
        w_value_next  = r_value;
        w_carry_next  = 1'b0;
        w_borrow_next = 1'b0;
        if (ld) begin
            w_value_next = (ld_val > w_top) ? w_top : ld_val;
        end else if (en) begin
            if (up) begin
                if (r_value >= w_top) begin
                    w_value_next = ZERO;
                    w_carry_next = 1'b1;
                end else begin
                    w_value_next = r_value + ONE;
                end
            end else begin
                if (r_value == ZERO) begin
                    w_value_next  = w_top;
                    w_borrow_next = 1'b1;
                end else if (r_value > w_top) begin
                    w_value_next = w_top;
                end else begin
                    w_value_next = r_value - ONE;
                end
            end
        end
    end

    // Decoding the next value keeps seg aligned with value on the same edge.
    assign w_dec_in    = rst ? RST_VALUE : w_value_next;
    assign w_dec_blank = rst ? 1'b0 : blank;

    seg7_decode #(
        .WIDTH      (WIDTH),
        .SEG_ACT_LO (SEG_ACT_LO)
    ) u_seg7_decode (
        .i_val   (w_dec_in),
        .i_blank (w_dec_blank),
        .o_seg   (w_seg_next)
    );

    always_ff @(posedge clk) begin
        r_seg <= w_seg_next;
        if (rst) begin
            r_value  <= RST_VALUE;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_value  <= w_value_next;
            r_carry  <= w_carry_next;
            r_borrow <= w_borrow_next;
        end
    end

    assign value  = r_value;
    assign seg    = r_seg;
    assign carry  = r_carry;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_digit_counter_mod.sv
// Scoreboard bench for digit_counter_mod (WIDTH=4, MODULO=10, active-low segments).
// Stimulus pushes hand-computed expectations; a monitor pops one per clock edge.
module tb_digit_counter_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       ld = 1'b0;
    logic [3:0] ld_val = 4'd0;
    logic [3:0] lim = 4'd9;
    logic       blank = 1'b0;
    logic [3:0] value;
    logic [6:0] seg;
    logic       carry;
    logic       borrow;

    typedef struct {
        logic [3:0] v;
        logic [6:0] s;
        logic       c;
        logic       b;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    digit_counter_mod #(
        .WIDTH      (4),
        .MODULO     (10),
        .RESET_VAL  (0),
        .SEG_ACT_LO (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .up     (up),
        .ld     (ld),
        .ld_val (ld_val),
        .lim    (lim),
        .blank  (blank),
        .value  (value),
        .seg    (seg),
        .carry  (carry),
        .borrow (borrow)
    );

    // Hand-written active-low digit table, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input int lv, input int lm, input logic bl,
                         input int ev, input logic [6:0] es, input logic ec,
                         input logic eb, input string nm);
        exp_t x;
        @(negedge clk);
        rst    = r;
        en     = e;
        up     = u;
        ld     = l;
        ld_val = 4'(lv);
        lim    = 4'(lm);
        blank  = bl;
        x.v  = 4'(ev);
        x.s  = es;
        x.c  = ec;
        x.b  = eb;
        x.nm = nm;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                $display("txn %s: value=%0d seg=%b carry=%b borrow=%b", x.nm, value, seg, carry, borrow);
                checks++;
                if (value !== x.v) begin
                    failures++;
                    $display("FAIL %s value: got %0d expected %0d", x.nm, value, x.v);
                end
                checks++;
                if (seg !== x.s) begin
                    failures++;
                    $display("FAIL %s seg: got %b expected %b", x.nm, seg, x.s);
                end
                checks++;
                if (carry !== x.c) begin
                    failures++;
                    $display("FAIL %s carry: got %b expected %b", x.nm, carry, x.c);
                end
                checks++;
                if (borrow !== x.b) begin
                    failures++;
                    $display("FAIL %s borrow: got %b expected %b", x.nm, borrow, x.b);
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        // reset
        drive(1, 0, 1, 0, 0, 9, 0, 0, seg_of(0), 0, 0, "reset");
        // ten up-counts with lim=9, carry only on 9->0
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, 1, 0, 0, 9, 0, i % 10, seg_of(i % 10), (i == 10), 0, $sformatf("up_%0d", i));
        end
        // down-wrap 0->9 with borrow, then plain decrement
        drive(0, 1, 0, 0, 0, 9, 0, 9, seg_of(9), 0, 1, "down_wrap");
        drive(0, 1, 0, 0, 0, 9, 0, 8, seg_of(8), 0, 0, "down_8");
        drive(0, 0, 0, 0, 0, 9, 0, 8, seg_of(8), 0, 0, "idle_hold");
        // run-time limit 3
        drive(0, 0, 1, 1, 2, 3, 0, 2, seg_of(2), 0, 0, "load_2");
        drive(0, 1, 1, 0, 0, 3, 0, 3, seg_of(3), 0, 0, "lim3_up_3");
        drive(0, 1, 1, 0, 0, 3, 0, 0, seg_of(0), 1, 0, "lim3_wrap");
        drive(0, 1, 0, 0, 0, 3, 0, 3, seg_of(3), 0, 1, "lim3_down_wrap");
        drive(0, 0, 1, 1, 7, 3, 0, 3, seg_of(3), 0, 0, "load_clamp");
        // load beats en; reset beats load
        drive(0, 1, 1, 1, 5, 9, 0, 5, seg_of(5), 0, 0, "ld_over_en");
        drive(1, 1, 1, 1, 7, 9, 0, 0, seg_of(0), 0, 0, "rst_over_ld");
        // value above a lowered limit
        drive(0, 0, 1, 1, 8, 9, 0, 8, seg_of(8), 0, 0, "load_8");
        drive(0, 0, 1, 0, 0, 3, 0, 8, seg_of(8), 0, 0, "lim3_hold_8");
        drive(0, 1, 1, 0, 0, 3, 0, 0, seg_of(0), 1, 0, "over_top_up");
        drive(0, 0, 1, 1, 9, 9, 0, 9, seg_of(9), 0, 0, "load_9");
        drive(0, 1, 0, 0, 0, 3, 0, 3, seg_of(3), 0, 0, "over_top_down");
        // blank
        drive(0, 0, 1, 1, 0, 9, 0, 0, seg_of(0), 0, 0, "load_0");
        drive(0, 0, 1, 0, 0, 9, 1, 0, 7'b1111111, 0, 0, "blank_hold");
        drive(0, 1, 1, 0, 0, 9, 1, 1, 7'b1111111, 0, 0, "blank_count");
        drive(0, 0, 1, 0, 0, 9, 0, 1, seg_of(1), 0, 0, "unblank");
        // back-to-back wraps with lim=1 give separated pulses
        drive(0, 1, 1, 0, 0, 1, 0, 0, seg_of(0), 1, 0, "lim1_wrap_a");
        drive(0, 1, 1, 0, 0, 1, 0, 1, seg_of(1), 0, 0, "lim1_up");
        drive(0, 1, 1, 0, 0, 1, 0, 0, seg_of(0), 1, 0, "lim1_wrap_b");
        drive(0, 0, 1, 0, 0, 9, 0, 0, seg_of(0), 0, 0, "final_idle");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d pending expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
